// File: rtl/mac_32_sequencer.sv
// mac_32_sequencer: runs one dot-product job at a time on an id-addressed MAC bank and returns the 32-bit result.
// Optional feature: define MAC_32_OVF_CHECK_EN to flag signed 32-bit overflow of the dot product on res_ovf.
module mac_32_sequencer #(
   parameter int NUM_UNITS = 2,
   parameter int ID_W      = $clog2(NUM_UNITS + 1),
   parameter int LEN_W     = 8
) (
   input  logic             clock0,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ID_W-1:0]  cmd_id,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [15:0]      op_a,
   input  logic [15:0]      op_b,
   output logic             mac_clr,
   output logic [ID_W-1:0]  mac_id,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   input  logic [31:0]      mac_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [ID_W-1:0]  res_id,
   output logic             res_err,
   output logic             res_ovf
);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN1, DRAIN2, RESULT} state_t;

   localparam logic [ID_W-1:0] NUM_ID = ID_W'(NUM_UNITS);

   state_t             state, state_next;
   logic [LEN_W-1:0]   remaining, remaining_next;
   logic               cmd_ready_next, op_ready_next, mac_clr_next;
   logic [ID_W-1:0]    mac_id_next, res_id_next;
   logic [15:0]        mac_a_next, mac_b_next;
   logic               res_valid_next, res_err_next, res_ovf_next;
   logic [31:0]        res_data_next;
   logic               cmd_hs, op_hs, res_hs;

   assign cmd_hs = cmd_valid && cmd_ready;
   assign op_hs  = op_valid && op_ready;
   assign res_hs = res_valid && res_ready;

`ifdef MAC_32_OVF_CHECK_EN
   localparam int SH_W = 32 + LEN_W;

   logic [SH_W-1:0] shadow;
   logic [31:0]     product;
   logic            shadow_ovf;

   assign product    = $signed({{16{op_a[15]}}, op_a}) * $signed({{16{op_b[15]}}, op_b});
   // Out of 32-bit range whenever the bits above bit 31 are not all copies of bit 31.
   assign shadow_ovf = (shadow[SH_W-1:31] != {(LEN_W + 1){shadow[31]}});

   always_ff @(posedge clock0) begin
      if (!reset_n)
         shadow <= '0;
      else if (state == CLEAR)
         shadow <= '0;
      else if (state == STREAM && op_hs)
         shadow <= shadow + {{LEN_W{product[31]}}, product};
   end
`else
`endif

   // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      cmd_ready_next = 1'b0;
      op_ready_next  = 1'b0;
      mac_clr_next   = 1'b0;
      mac_id_next    = mac_id;
      mac_a_next     = '0;
      mac_b_next     = '0;
      res_valid_next = res_valid;
      res_data_next  = res_data;
      res_id_next    = res_id;
      res_err_next   = res_err;
      res_ovf_next   = res_ovf;

      case (state)
         IDLE: begin
            cmd_ready_next = 1'b1;
            if (cmd_hs) begin
               cmd_ready_next = 1'b0;
               mac_id_next    = cmd_id;
               remaining_next = cmd_len;
               if (cmd_id >= NUM_ID) begin
                  // Unknown lane: skip the bank entirely and report an error result.
                  state_next     = RESULT;
                  res_valid_next = 1'b1;
                  res_data_next  = '0;
                  res_id_next    = cmd_id;
                  res_err_next   = 1'b1;
                  res_ovf_next   = 1'b0;
               end else begin
                  state_next   = CLEAR;
                  mac_clr_next = 1'b1;
               end
            end
         end

         CLEAR: begin
            if (remaining == '0) begin
               state_next = DRAIN1;
            end else begin
               state_next    = STREAM;
               op_ready_next = 1'b1;
            end
         end

         STREAM: begin
            if (op_hs) begin
               mac_a_next     = op_a;
               mac_b_next     = op_b;
               remaining_next = remaining - 1'b1;
               op_ready_next  = (remaining != LEN_W'(1));
            end else if (remaining == '0) begin
               state_next = DRAIN1;
            end else begin
               op_ready_next = 1'b1;
            end
         end

         DRAIN1: state_next = DRAIN2;

         DRAIN2: begin
            state_next     = RESULT;
            res_valid_next = 1'b1;
            res_data_next  = mac_out;
            res_id_next    = mac_id;
            res_err_next   = 1'b0;
`ifdef MAC_32_OVF_CHECK_EN
            res_ovf_next   = shadow_ovf;
`else
            res_ovf_next   = 1'b0;
`endif
         end

         RESULT: begin
            if (res_hs) begin
               state_next     = IDLE;
               res_valid_next = 1'b0;
               cmd_ready_next = 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock0) begin
      if (!reset_n) begin
         state     <= IDLE;
         remaining <= '0;
         cmd_ready <= 1'b0;
         op_ready  <= 1'b0;
         mac_clr   <= 1'b1;
         mac_id    <= '0;
         mac_a     <= '0;
         mac_b     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         res_err   <= 1'b0;
         res_ovf   <= 1'b0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         cmd_ready <= cmd_ready_next;
         op_ready  <= op_ready_next;
         mac_clr   <= mac_clr_next;
         mac_id    <= mac_id_next;
         mac_a     <= mac_a_next;
         mac_b     <= mac_b_next;
         res_valid <= res_valid_next;
         res_data  <= res_data_next;
         res_id    <= res_id_next;
         res_err   <= res_err_next;
         res_ovf   <= res_ovf_next;
      end
   end

endmodule

// File: tb/tb_mac_32_sequencer.sv
// tb_mac_32_sequencer: drives jobs into mac_32_sequencer attached to a two-stage MAC bank model and
// scoreboards results against a plain-arithmetic dot-product reference.
module tb_mac_32_sequencer;

   localparam int NUM_UNITS = 2;
   localparam int ID_W      = $clog2(NUM_UNITS + 1);
   localparam int LEN_W     = 8;

   logic             clock0 = 1'b0;
   logic             reset_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [ID_W-1:0]  cmd_id;
   logic [LEN_W-1:0] cmd_len;
   logic             op_valid;
   logic             op_ready;
   logic [15:0]      op_a, op_b;
   logic             mac_clr;
   logic [ID_W-1:0]  mac_id;
   logic [15:0]      mac_a, mac_b;
   logic [31:0]      mac_out;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [ID_W-1:0]  res_id;
   logic             res_err;
   logic             res_ovf;

   mac_32_sequencer #(.NUM_UNITS(NUM_UNITS), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
      .clock0(clock0), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .mac_clr(mac_clr), .mac_id(mac_id), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
      .res_err(res_err), .res_ovf(res_ovf)
   );

   always #5 clock0 = ~clock0;

   int cyc = 0;
   always @(posedge clock0) cyc <= cyc + 1;

   function automatic int mul16(input logic [15:0] a, input logic [15:0] b);
      int ia, ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      return ia * ib;
   endfunction

   // Bank model: product register, then per-lane accumulator; clear wipes every lane.
   int              acc [4];
   int              prod_q;
   logic [ID_W-1:0] pid_q;
   always @(posedge clock0) begin
      if (mac_clr) begin
         for (int i = 0; i < 4; i++) acc[i] <= 0;
         prod_q <= 0;
         pid_q  <= '0;
      end else begin
         prod_q <= mul16(mac_a, mac_b);
         pid_q  <= mac_id;
         if (int'(pid_q) < NUM_UNITS) acc[pid_q] <= acc[pid_q] + prod_q;
      end
   end
   assign mac_out = (int'(mac_id) < NUM_UNITS) ? acc[mac_id] : 32'd0;

   typedef struct {
      logic [31:0]     data;
      logic [ID_W-1:0] id;
      logic            err;
      logic            ovf;
      int              nops;
      bit              lat;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [15:0] opa [256];
   logic [15:0] opb [256];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          hold_ready = 1'b0;
   int          op_cnt = 0;
   int          last_hs = 0;
   bit          prev_rv = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input int id, input int len);
      exp_t   e;
      longint sum;
      sum    = 0;
      e.id   = ID_W'(id);
      e.err  = (id >= NUM_UNITS);
      e.nops = e.err ? 0 : len;
      e.lat  = !e.err && (len > 0);
      if (!e.err)
         for (int i = 0; i < len; i++) sum += longint'(mul16(opa[i], opb[i]));
      e.data = sum[31:0];
`ifdef MAC_32_OVF_CHECK_EN
      e.ovf  = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
`else
      e.ovf  = 1'b0;
`endif
      return e;
   endfunction

   task automatic issue_cmd(input int id, input int len);
      int t;
      exp_q.push_back(model(id, len));
      cmd_id    = ID_W'(id);
      cmd_len   = LEN_W'(len);
      cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 400) begin
         @(posedge clock0); #1;
         t++;
      end
      check("cmd_accept", cmd_ready, 1'b1);
      @(posedge clock0); #1;
      cmd_valid = 1'b0;
   endtask

   // mode 0: continuous, 1: op_valid toggles each cycle, 2: random gaps
   task automatic stream_ops(input int count, input int mode);
      int i, t;
      i = 0;
      t = 0;
      while (i < count && t < 64 + 8 * count) begin
         op_a = opa[i];
         op_b = opb[i];
         case (mode)
            0:       op_valid = 1'b1;
            1:       op_valid = (t % 2 == 0);
            default: op_valid = ($urandom_range(0, 2) != 0);
         endcase
         if (op_valid && op_ready) i++;
         t++;
         @(posedge clock0); #1;
      end
      op_valid = 1'b0;
      check("ops_streamed", i, count);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clock0); #1;
         t++;
      end
      check("drain_results", exp_q.size(), 0);
   endtask

   task automatic check_reset_values();
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_op_ready",  op_ready,  1'b0);
      check("rst_mac_clr",   mac_clr,   1'b1);
      check("rst_mac_a",     mac_a,     16'd0);
      check("rst_mac_b",     mac_b,     16'd0);
      check("rst_mac_id",    mac_id,    '0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_data",  res_data,  32'd0);
      check("rst_res_id",    res_id,    '0);
      check("rst_res_err",   res_err,   1'b0);
      check("rst_res_ovf",   res_ovf,   1'b0);
   endtask

   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clock0); #1;
         res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: samples on the falling edge, compares presented results against the queue head.
   initial begin
      forever begin
         @(negedge clock0);
         if (!reset_n) begin
            op_cnt  = 0;
            prev_rv = 1'b0;
         end else begin
            if (op_valid && op_ready) begin
               op_cnt++;
               last_hs = cyc + 1;
            end
            if (res_valid) begin
               check("cmd_ready_during_result", cmd_ready, 1'b0);
               if (exp_q.size() == 0) begin
                  check("unexpected_result", res_valid, 1'b0);
               end else begin
                  cur = exp_q[0];
                  check("res_data", res_data, cur.data);
                  check("res_id",   res_id,   cur.id);
                  check("res_err",  res_err,  cur.err);
                  check("res_ovf",  res_ovf,  cur.ovf);
                  if (!prev_rv) begin
                     check("ops_consumed", op_cnt, cur.nops);
                     if (cur.lat) check("result_latency", cyc - last_hs, 3);
                  end
                  if (res_ready) begin
                     void'(exp_q.pop_front());
                     op_cnt = 0;
                  end
               end
            end
            prev_rv = res_valid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d results pending", exp_q.size());
      $fatal(1);
   end

   initial begin
      int t;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_id    = '0;
      cmd_len   = '0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      repeat (3) @(posedge clock0);
      #1;
      check_reset_values();
      reset_n = 1'b1;
      @(posedge clock0); #1;

      // Mixed-sign dot product on lane 0: -72.
      opa[0] = 16'd1;  opb[0] = 16'd2;
      opa[1] = 16'd3;  opb[1] = 16'd4;
      opa[2] = -16'sd5; opb[2] = 16'd6;
      opa[3] = 16'd7;  opb[3] = -16'sd8;
      issue_cmd(0, 4);
      stream_ops(4, 0);
      drain();

      // Lane 1 with op_valid gaps; lane 0 must have been cleared and left alone.
      for (int i = 0; i < 3; i++) begin opa[i] = 16'd100; opb[i] = 16'd100; end
      issue_cmd(1, 3);
      stream_ops(3, 1);
      drain();
      check("lane0_untouched", acc[0], 0);

      // Zero-length job and rejected id while operands are offered the whole time.
      op_valid = 1'b1;
      op_a     = 16'h1234;
      op_b     = 16'h0042;
      issue_cmd(1, 0);
      drain();
      issue_cmd(2, 5);
      drain();
      issue_cmd(3, 0);
      drain();
      op_valid = 1'b0;

      // Wrapping sum of three maximal positive products.
      for (int i = 0; i < 3; i++) begin opa[i] = 16'h8000; opb[i] = 16'h8000; end
      issue_cmd(0, 3);
      stream_ops(3, 0);
      drain();

      // Back-pressure: result must hold while a second command waits.
      hold_ready = 1'b1;
      opa[0] = 16'd300; opb[0] = -16'sd7;
      opa[1] = 16'd11;  opb[1] = 16'd13;
      issue_cmd(1, 2);
      stream_ops(2, 0);
      t = 0;
      while (!res_valid && t < 20) begin @(posedge clock0); #1; t++; end
      check("hold_result_seen", res_valid, 1'b1);
      fork
         begin
            repeat (10) @(posedge clock0);
            #1;
            hold_ready = 1'b0;
         end
         begin
            opa[0] = 16'd5; opb[0] = 16'd9;
            issue_cmd(0, 1);
            stream_ops(1, 2);
         end
      join
      drain();

      // Reset in the middle of streaming abandons the job.
      for (int i = 0; i < 5; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'd1000; end
      issue_cmd(0, 5);
      stream_ops(2, 0);
      reset_n = 1'b0;
      exp_q.delete();
      @(posedge clock0); #1;
      check_reset_values();
      reset_n = 1'b1;
      @(posedge clock0); #1;
      for (int i = 0; i < 5; i++) begin opa[i] = 16'(i + 1); opb[i] = -16'sd1000; end
      issue_cmd(1, 5);
      stream_ops(5, 0);
      drain();

      // Randomised jobs, including rejected ids and gapped operands.
      for (int j = 0; j < 30; j++) begin
         int id, len, mode;
         id   = $urandom_range(0, 3);
         len  = ($urandom_range(0, 4) == 0) ? $urandom_range(11, 40) : $urandom_range(0, 10);
         mode = $urandom_range(0, 2);
         for (int i = 0; i < len; i++) begin
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
         end
         issue_cmd(id, len);
         if (id < NUM_UNITS && len > 0) stream_ops(len, mode);
      end
      drain();

      // Longest job with the largest products.
      for (int i = 0; i < 255; i++) begin opa[i] = 16'h8000; opb[i] = 16'h8000; end
      issue_cmd(1, 255);
      stream_ops(255, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
